mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory-access (MA) stage. Consumes the load/store/writeback command set that the execution stage drives toward MA.
- Drives the data-memory request/acknowledge port: byte enables, store-data replication, load alignment and sign/zero extension.
- Registers the result toward the writeback (WB) stage.
- Stalls the upstream pipeline while a memory access is outstanding; aborts accesses that exceed a timeout.

Parameters:
- WAIT_MAX, 15: maximum BUSY cycles without dmem_ack before abort; must be 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_ld_ma  in  1  load command valid
- cmd_st_ma  in  1  store command valid
- wbk_rd_reg_ma  in  1  rd writeback request
- rd_adr_ma  in  5  destination register
- rd_data_ma  in  32  ALU result; the effective address for ld/st
- st_data_ma  in  32  store data (rs2)
- ldst_code_ma  in  3  funct3: [1:0] size (00 byte, 01 half, 10 word), [2] unsigned
- stall_ma  out  1  hold upstream stages
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_adr  out  30  word address [31:2]
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  write data
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  request complete
- dmem_err  out  1  timeout pulse
- wbk_rd_reg_wb  out  1  writeback valid pulse
- rd_adr_wb  out  5  writeback register
- rd_data_wb  out  32  writeback data
- ma_misalign_ld  out  1  misaligned-load pulse
- ma_misalign_st  out  1  misaligned-store pulse
- ma_bad_adr  out  32  faulting address

Behaviour:
- Reset: all outputs and registers are 0, state is IDLE. Reset asserted mid-access drops dmem_req immediately, abandons the access, and produces no writeback.
- FSM has two states, IDLE and BUSY.
- IDLE, cmd_ld_ma or cmd_st_ma high, access aligned:
  - capture address, be, wdata, we, rd_adr, size/sign;
  - go to BUSY, clear the counter;
  - assert stall_ma combinationally in this same cycle.
- IDLE, only wbk_rd_reg_ma high: register rd_adr_ma/rd_data_ma to the WB outputs next cycle; wbk_rd_reg_wb=1 for one cycle.
- IDLE, no command: wbk_rd_reg_wb=0; rd_data_wb and rd_adr_wb hold their values.
- cmd_ld_ma and cmd_st_ma both high is illegal. The load takes priority.
- BUSY:
  - dmem_req=1 with the registered adr/be/we/wdata, all held stable until ack;
  - stall_ma=1 except in the ack/abort cycle;
  - inputs are ignored.
- BUSY with dmem_ack:
  - load: extended data goes to rd_data_wb and wbk_rd_reg_wb pulses next cycle;
  - store: no writeback;
  - return to IDLE.
- Minimum latency: command at cycle N, req at N+1, ack at N+1, WB valid at N+2.
- BUSY, counter reaches WAIT_MAX without ack:
  - drop req, pulse dmem_err one cycle, return to IDLE;
  - a timed-out load writes back 0 to rd_adr.
- dmem_ack arriving in the same cycle as the counter hitting WAIT_MAX: the ack wins.
- Byte enables:
  - byte: be = 1 << adr[1:0], wdata = {4{st[7:0]}};
  - half: be = adr[1] ? 1100 : 0011, wdata = {2{st[15:0]}};
  - word: be = 1111.
- Load data: select the lane by adr[1:0] and size; sign-extend unless ldst_code[2]=1, in which case zero-extend.
- A store never asserts wbk_rd_reg_wb, even if wbk_rd_reg_ma=1.

Optional Feature:
- Macro: MA_MISALIGN_TRAP_EN.
- Defined:
  - half with adr[0]=1, or word with adr[1:0]!=0, issues no dmem_req and stays in IDLE;
  - the next cycle pulses ma_misalign_ld or ma_misalign_st and sets ma_bad_adr to the address;
  - no writeback.
- Undefined:
  - ma_misalign_* and ma_bad_adr are tied to 0;
  - the misaligned low bits are ignored: half uses adr[1] only, word uses adr[1:0]=00.

Decomposition:
- Shared package holds:
  - constants LDST_B=2'b00, LDST_H=2'b01, LDST_W=2'b10, LDST_U_BIT=2;
  - state encoding MA_IDLE/MA_BUSY.
- Sub-module ma_lane: pure combinational byte-enable, store-replication and load-extension logic. The FSM, counter and WB registers stay in mem_access.

Test Plan:
- Store byte: adr 0x103, st 0x000000AB, zero-wait ack → dmem_be=1000, dmem_wdata=0xABABABAB, dmem_adr=0x40, no wbk_rd_reg_wb.
- Load byte signed then unsigned: adr 0x102, rdata 0x00800000:
  - LB → rd_data_wb=0xFFFFFF80;
  - LBU → 0x00000080.
- ack delayed 5 cycles on LW: stall_ma=1 for 6 cycles, req and adr stable, wbk_rd_reg_wb pulses exactly once with rdata.
- No ack for WAIT_MAX=15 cycles: dmem_err pulses one cycle, rd_data_wb=0, state IDLE, next command accepted.
- With MA_MISALIGN_TRAP_EN: LH at 0x201 → ma_misalign_ld=1 for one cycle, ma_bad_adr=0x201, dmem_req never asserted. Without the macro, the same access reads with be=0011.
- rst_n asserted while in BUSY → dmem_req=0 and stall_ma=0 asynchronously, no WB pulse after reset release.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants and types for the memory-access stage.
package mem_access_pkg;

    localparam logic [1:0] LDST_B     = 2'b00;
    localparam logic [1:0] LDST_H     = 2'b01;
    localparam logic [1:0] LDST_W     = 2'b10;
    localparam int         LDST_U_BIT = 2;
    localparam int         NUM_LANES  = 4;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_BUSY = 1'b1
    } ma_state_e;

    // Access captured at command time and held for the whole BUSY phase.
    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [4:0]  rd_adr;
        logic [1:0]  size;
        logic        uns;
    } ma_req_t;

    // Size encoding 2'b11 is treated as a word everywhere.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] adr_lo);
        logic mis;
        mis = 1'b0;
        if (size == LDST_H)
            mis = adr_lo[0];
        else if (size != LDST_B)
            mis = (adr_lo != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/ma_lane.sv
// Combinational byte-lane logic: byte enables, store replication, load extraction/extension.
module ma_lane
    import mem_access_pkg::*;
(
    input  logic [1:0]  adr_lo,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [7:0]  rb;
    logic [15:0] rh;

    // Halves only look at adr[1]; words ignore the low bits entirely.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LN = 2'(i);
        localparam int         HB = 8 * (i % 2);
        assign be[i] = (size == LDST_B) ? (adr_lo == LN) :
                       (size == LDST_H) ? (adr_lo[1] == LN[1]) : 1'b1;
        assign wdata[8*i +: 8] = (size == LDST_B) ? st_data[7:0] :
                                 (size == LDST_H) ? st_data[HB +: 8] : st_data[8*i +: 8];
    end

    assign rb = rdata[{adr_lo, 3'b000} +: 8];
    assign rh = adr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        ld_data = rdata;
        case (size)
            LDST_B:  ld_data = {{24{~uns & rb[7]}}, rb};
            LDST_H:  ld_data = {{16{~uns & rh[15]}}, rh};
            default: ld_data = rdata;
        endcase
    end

    assign misalign = is_misaligned(size, adr_lo);

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives the dmem req/ack port, stalls upstream, registers WB.
// Optional misaligned-access trap enabled by defining MA_MISALIGN_TRAP_EN.
module mem_access #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_ld_ma,
    input  logic        cmd_st_ma,
    input  logic        wbk_rd_reg_ma,
    input  logic [4:0]  rd_adr_ma,
    input  logic [31:0] rd_data_ma,
    input  logic [31:0] st_data_ma,
    input  logic [2:0]  ldst_code_ma,
    output logic        stall_ma,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_adr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        dmem_err,
    output logic        wbk_rd_reg_wb,
    output logic [4:0]  rd_adr_wb,
    output logic [31:0] rd_data_wb,
    output logic        ma_misalign_ld,
    output logic        ma_misalign_st,
    output logic [31:0] ma_bad_adr
);

    import mem_access_pkg::*;

    ma_state_e        state_q, state_d;
    ma_req_t          req_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy, is_cmd, trap, accept, timeout, done;
    logic [1:0]       lane_adr, lane_size;
    logic             lane_uns;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata, lane_ld;
    logic             lane_mis;

    assign busy    = (state_q == MA_BUSY);
    assign is_cmd  = cmd_ld_ma | cmd_st_ma;

`ifdef MA_MISALIGN_TRAP_EN
    assign trap    = ~busy & is_cmd & lane_mis;
`else
    logic unused_mis;
    assign unused_mis = lane_mis;
    assign trap       = 1'b0;
`endif

    assign accept  = ~busy & is_cmd & ~trap;
    // An ack in the final wait cycle beats the timeout.
    assign timeout = busy & ~dmem_ack & (cnt_q == CNT_W'(WAIT_MAX));
    assign done    = busy & (dmem_ack | timeout);

    // In IDLE the lane decodes the incoming command; in BUSY it extracts the held load.
    assign lane_adr  = busy ? req_q.adr[1:0] : rd_data_ma[1:0];
    assign lane_size = busy ? req_q.size     : ldst_code_ma[1:0];
    assign lane_uns  = busy ? req_q.uns      : ldst_code_ma[LDST_U_BIT];

    ma_lane u_lane (
        .adr_lo   (lane_adr),
        .size     (lane_size),
        .uns      (lane_uns),
        .st_data  (st_data_ma),
        .rdata    (dmem_rdata),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .ld_data  (lane_ld),
        .misalign (lane_mis)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MA_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MA_IDLE: if (accept) state_d = MA_BUSY;
            MA_BUSY: if (done)   state_d = MA_IDLE;
            default: state_d = MA_IDLE;
        endcase
    end

    always_comb begin
        stall_ma = accept | (busy & ~done);
        dmem_req = busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt_q <= '0;
        else if (accept)           cnt_q <= '0;
        else if (busy && !done)    cnt_q <= cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.adr    <= rd_data_ma;
            req_q.be     <= lane_be;
            req_q.we     <= ~cmd_ld_ma;
            req_q.wdata  <= lane_wdata;
            req_q.rd_adr <= rd_adr_ma;
            req_q.size   <= ldst_code_ma[1:0];
            req_q.uns    <= ldst_code_ma[LDST_U_BIT];
        end
    end

    assign dmem_we    = req_q.we;
    assign dmem_adr   = req_q.adr[31:2];
    assign dmem_be    = req_q.be;
    assign dmem_wdata = req_q.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbk_rd_reg_wb <= 1'b0;
            rd_adr_wb     <= '0;
            rd_data_wb    <= '0;
            dmem_err      <= 1'b0;
        end else begin
            wbk_rd_reg_wb <= 1'b0;
            dmem_err      <= timeout;
            if (busy) begin
                // Timed-out loads still retire, writing 0.
                if (done && !req_q.we) begin
                    wbk_rd_reg_wb <= 1'b1;
                    rd_adr_wb     <= req_q.rd_adr;
                    rd_data_wb    <= dmem_ack ? lane_ld : '0;
                end
            end else if (!is_cmd && wbk_rd_reg_ma) begin
                wbk_rd_reg_wb <= 1'b1;
                rd_adr_wb     <= rd_adr_ma;
                rd_data_wb    <= rd_data_ma;
            end
        end
    end

`ifdef MA_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ma_misalign_ld <= 1'b0;
            ma_misalign_st <= 1'b0;
            ma_bad_adr     <= '0;
        end else begin
            ma_misalign_ld <= trap & cmd_ld_ma;
            ma_misalign_st <= trap & ~cmd_ld_ma;
            if (trap) ma_bad_adr <= rd_data_ma;
        end
    end
`else
    assign ma_misalign_ld = 1'b0;
    assign ma_misalign_st = 1'b0;
    assign ma_bad_adr     = '0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Randomized and directed bench for mem_access against a byte-lane arithmetic model.
module tb_mem_access;

    localparam int WAIT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_ld_ma, cmd_st_ma, wbk_rd_reg_ma;
    logic [4:0]  rd_adr_ma;
    logic [31:0] rd_data_ma, st_data_ma;
    logic [2:0]  ldst_code_ma;
    logic        stall_ma, dmem_req, dmem_we;
    logic [29:0] dmem_adr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        dmem_ack, dmem_err;
    logic        wbk_rd_reg_wb;
    logic [4:0]  rd_adr_wb;
    logic [31:0] rd_data_wb;
    logic        ma_misalign_ld, ma_misalign_st;
    logic [31:0] ma_bad_adr;

    int pass_cnt = 0;
    int total    = 0;

    logic [4:0]  m_rd_adr  = '0;
    logic [31:0] m_rd_data = '0;

    mem_access #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_ld_ma(cmd_ld_ma), .cmd_st_ma(cmd_st_ma), .wbk_rd_reg_ma(wbk_rd_reg_ma),
        .rd_adr_ma(rd_adr_ma), .rd_data_ma(rd_data_ma), .st_data_ma(st_data_ma),
        .ldst_code_ma(ldst_code_ma), .stall_ma(stall_ma), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_adr(dmem_adr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .wbk_rd_reg_wb(wbk_rd_reg_wb), .rd_adr_wb(rd_adr_wb), .rd_data_wb(rd_data_wb),
        .ma_misalign_ld(ma_misalign_ld), .ma_misalign_st(ma_misalign_st), .ma_bad_adr(ma_bad_adr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'd0) return 4'(1 << int'(a));
        if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] st);
        if (sz == 2'd0) return {4{st[7:0]}};
        if (sz == 2'd1) return {2{st[15:0]}};
        return st;
    endfunction

    // Shift the addressed lane down, mask to size, then sign-extend arithmetically.
    function automatic logic [31:0] m_ld(input logic [1:0] sz, input logic uns,
                                         input logic [1:0] a, input logic [31:0] rd);
        int     sh, bits;
        longint v;
        sh   = (sz == 2'd0) ? int'(a) * 8 : (sz == 2'd1) ? (a[1] ? 16 : 0) : 0;
        bits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        v    = (longint'(rd) >> sh) & ((longint'(1) << bits) - 1);
        if (!uns && bits < 32 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    task automatic access(input bit ld, input bit both, input logic [31:0] adr,
                          input logic [31:0] st, input logic [2:0] code, input int delay,
                          input logic [31:0] rdata, input bit wbk_in, input logic [4:0] rd);
        bit          trap;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        trap = 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
        trap = (code[1:0] == 2'b01 && adr[0]) || (code[1:0] == 2'b10 && adr[1:0] != 2'b00);
`endif
        ebe = m_be(code[1:0], adr[1:0]);
        ewd = m_wd(code[1:0], st);
        step();
        cmd_ld_ma = ld; cmd_st_ma = !ld || both; wbk_rd_reg_ma = wbk_in;
        rd_adr_ma = rd; rd_data_ma = adr; st_data_ma = st; ldst_code_ma = code;
        #1 chk("cmd_stall", {stall_ma, dmem_req}, {!trap, 1'b0});
        step();
        cmd_ld_ma = 0; cmd_st_ma = 0; wbk_rd_reg_ma = 0;
        rd_data_ma = $urandom; st_data_ma = $urandom; ldst_code_ma = 3'($urandom);
        if (trap) begin
            #1 chk("trap_pulse", {ma_misalign_ld, ma_misalign_st, dmem_req, wbk_rd_reg_wb},
                   {ld, !ld, 1'b0, 1'b0});
            chk("trap_adr", ma_bad_adr, adr);
            step();
            chk("trap_once", {ma_misalign_ld, ma_misalign_st, dmem_req}, 0);
            return;
        end
        for (int k = 0; k <= WAIT_MAX; k++) begin
            #1 chk("busy_bus", {dmem_req, dmem_we, dmem_be, dmem_adr}, {1'b1, !ld, ebe, adr[31:2]});
            if (!ld) chk("busy_wdata", dmem_wdata, ewd);
            if (k == delay) begin
                dmem_ack = 1; dmem_rdata = rdata;
                #1 chk("ack_stall", stall_ma, 0);
                step();
                dmem_ack = 0; dmem_rdata = $urandom;
                if (ld) begin
                    m_rd_adr  = rd;
                    m_rd_data = m_ld(code[1:0], code[2], adr[1:0], rdata);
                end
                chk("ack_wb", {dmem_req, dmem_err, wbk_rd_reg_wb, rd_adr_wb, rd_data_wb},
                    {1'b0, 1'b0, ld, m_rd_adr, m_rd_data});
                break;
            end else if (k == WAIT_MAX) begin
                chk("abort_stall", stall_ma, 0);
                step();
                if (ld) begin
                    m_rd_adr  = rd;
                    m_rd_data = '0;
                end
                chk("abort_wb", {dmem_req, dmem_err, wbk_rd_reg_wb, rd_adr_wb, rd_data_wb},
                    {1'b0, 1'b1, ld, m_rd_adr, m_rd_data});
            end else begin
                chk("busy_stall", stall_ma, 1);
                step();
            end
        end
        step();
        chk("idle_after", {wbk_rd_reg_wb, dmem_err, dmem_req, stall_ma}, 0);
    endtask

    initial begin
        bit          ld, both;
        logic [2:0]  code;
        int          dly, r;
        rst_n = 0;
        cmd_ld_ma = 0; cmd_st_ma = 0; wbk_rd_reg_ma = 0; rd_adr_ma = 0;
        rd_data_ma = 0; st_data_ma = 0; ldst_code_ma = 0; dmem_rdata = 0; dmem_ack = 0;
        repeat (3) step();
        chk("rst_ctl", {stall_ma, dmem_req, dmem_we, dmem_err, wbk_rd_reg_wb,
                        ma_misalign_ld, ma_misalign_st}, 0);
        chk("rst_bus", {dmem_adr, dmem_be}, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb", {rd_adr_wb, rd_data_wb}, 0);
        chk("rst_bad", ma_bad_adr, 0);
        rst_n = 1;
        step();

        // Plain register writeback, then hold.
        wbk_rd_reg_ma = 1; rd_adr_ma = 5'd5; rd_data_ma = 32'h1234_5678;
        step();
        wbk_rd_reg_ma = 0; rd_adr_ma = 5'd9; rd_data_ma = 32'hDEAD_BEEF;
        m_rd_adr = 5'd5; m_rd_data = 32'h1234_5678;
        chk("wb_pulse", {wbk_rd_reg_wb, rd_adr_wb, rd_data_wb}, {1'b1, m_rd_adr, m_rd_data});
        step();
        chk("wb_hold", {wbk_rd_reg_wb, rd_adr_wb, rd_data_wb, stall_ma}, {1'b0, m_rd_adr, m_rd_data, 1'b0});

        access(0, 0, 32'h103, 32'h0000_00AB, 3'b000, 0, 32'h0, 1, 5'd3);
        access(1, 0, 32'h102, 32'h0, 3'b000, 0, 32'h0080_0000, 0, 5'd7);
        access(1, 0, 32'h102, 32'h0, 3'b100, 0, 32'h0080_0000, 0, 5'd8);
        access(1, 0, 32'h400, 32'h0, 3'b010, 5, 32'hCAFE_F00D, 0, 5'd10);
        access(1, 0, 32'h500, 32'h0, 3'b010, 1000, 32'h1111_1111, 0, 5'd11);
        access(0, 0, 32'h504, 32'h5566_7788, 3'b010, 1000, 32'h0, 0, 5'd12);
        access(1, 0, 32'h600, 32'h0, 3'b001, WAIT_MAX, 32'h8001_8002, 0, 5'd13);
        access(1, 1, 32'h704, 32'h0, 3'b010, 1, 32'h0BAD_F00D, 0, 5'd14);
        access(1, 0, 32'h201, 32'h0, 3'b001, 0, 32'h0000_9ABC, 0, 5'd15);
        access(0, 0, 32'h203, 32'hA5A5_1234, 3'b001, 2, 32'h0, 1, 5'd16);
        access(0, 0, 32'h302, 32'h8765_4321, 3'b010, 0, 32'h0, 0, 5'd17);

        for (int i = 0; i < 30; i++) begin
            ld   = 1'($urandom_range(0, 1));
            both = ld && ($urandom_range(0, 7) == 0);
            code = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
            r    = int'($urandom_range(0, 9));
            dly  = (r < 7) ? int'($urandom_range(0, 4)) : (r == 7) ? WAIT_MAX : (r == 8) ? 1000 : 1;
            access(ld, both, $urandom, $urandom, code, dly, $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom));
        end

        // Reset in the middle of a load: bus drops at once, nothing retires.
        step();
        cmd_ld_ma = 1; rd_data_ma = 32'h800; ldst_code_ma = 3'b010; rd_adr_ma = 5'd21;
        step();
        cmd_ld_ma = 0;
        step();
        #1 rst_n = 0;
        #1 chk("rst_mid", {dmem_req, stall_ma}, 0);
        step();
        step();
        rst_n = 1;
        m_rd_adr = '0; m_rd_data = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_wb", {wbk_rd_reg_wb, dmem_req, rd_adr_wb, rd_data_wb}, 0);
        end
        access(1, 0, 32'h900, 32'h0, 3'b010, 0, 32'h1357_9BDF, 0, 5'd22);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
